// File: rtl/fusioncap_window_collector.sv
`default_nettype none
// ==========================================================================
// fusioncap_window_collector - gathers 10-sample windows, fires the averaging
// PE, then returns each captured average tagged with its channel.  Rev 1.0
// ==========================================================================
module fusioncap_window_collector #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5,
  parameter int PE_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic [DATA_W-1:0] x8,
  output logic [DATA_W-1:0] x9,
  output logic              pe_start,
  input  logic [DATA_W-1:0] pe_odata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_last,
  output logic              busy
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  localparam int                WAIT_W    = $clog2(PE_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PE_LAT - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [3:0]        FILL_LAST = 4'd9;

  logic [1:0]        state_q, state_d;
  logic [3:0]        fill_cnt_q, fill_cnt_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] slot_q [10];
  logic [DATA_W-1:0] slot_d [10];
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;

  logic accept;
  logic capture;

  assign accept  = (state_q == ST_FILL) && in_valid;
  assign capture = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept && (fill_cnt_q == FILL_LAST)) state_d = ST_FIRE;
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: if (capture) state_d = ST_EMIT;
      ST_EMIT: if (res_ready) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == ST_FILL);
    pe_start = (state_q == ST_FIRE);
    busy     = (state_q != ST_FILL) || (fill_cnt_q != 4'd0);
  end

  // Slots are only written in FILL so the PE sees stable inputs until capture
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slot_d      = slot_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    if (accept) begin
      for (int i = 0; i < 10; i++) begin
        if (fill_cnt_q == 4'(i)) slot_d[i] = in_data;
      end
      fill_cnt_d = (fill_cnt_q == FILL_LAST) ? 4'd0 : fill_cnt_q + 4'd1;
    end
    if (state_q == ST_FIRE) wait_cnt_d = '0;
    if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = pe_odata;
      res_ch_d    = ch_cnt_q;
    end
    if ((state_q == ST_EMIT) && res_ready) begin
      res_valid_d = 1'b0;
      ch_cnt_d    = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q  <= '0;
      ch_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      for (int i = 0; i < 10; i++) slot_q[i] <= '0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      for (int i = 0; i < 10; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign x0 = slot_q[0];
  assign x1 = slot_q[1];
  assign x2 = slot_q[2];
  assign x3 = slot_q[3];
  assign x4 = slot_q[4];
  assign x5 = slot_q[5];
  assign x6 = slot_q[6];
  assign x7 = slot_q[7];
  assign x8 = slot_q[8];
  assign x9 = slot_q[9];

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_last  = res_valid_q && (res_ch_q == CH_LAST);

endmodule
`default_nettype wire

// File: tb/tb_fusioncap_window_collector.sv
`default_nettype none
// Bench for fusioncap_window_collector: two instances (32 and 3 channels) in
// lockstep, each driving a behavioural averaging PE.
module tb_fusioncap_window_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b1;
  logic [15:0] in_data = 16'd0;

  always #5 clk = ~clk;

  logic [15:0] xa [0:9];
  logic [15:0] xb [0:9];
  logic        in_ready_a, pe_start_a, res_valid_a, res_last_a, busy_a;
  logic        in_ready_b, pe_start_b, res_valid_b, res_last_b, busy_b;
  logic [15:0] pe_a, pe_b, res_data_a, res_data_b;
  logic [4:0]  res_ch_a;
  logic [1:0]  res_ch_b;

  fusioncap_window_collector #(.DATA_W(16), .NUM_CH(32), .CH_W(5), .PE_LAT(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]),
    .x5(xa[5]), .x6(xa[6]), .x7(xa[7]), .x8(xa[8]), .x9(xa[9]),
    .pe_start(pe_start_a), .pe_odata(pe_a), .res_valid(res_valid_a), .res_ready(res_ready),
    .res_data(res_data_a), .res_ch(res_ch_a), .res_last(res_last_a), .busy(busy_a)
  );

  fusioncap_window_collector #(.DATA_W(16), .NUM_CH(3), .CH_W(2), .PE_LAT(5)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]),
    .x5(xb[5]), .x6(xb[6]), .x7(xb[7]), .x8(xb[8]), .x9(xb[9]),
    .pe_start(pe_start_b), .pe_odata(pe_b), .res_valid(res_valid_b), .res_ready(res_ready),
    .res_data(res_data_b), .res_ch(res_ch_b), .res_last(res_last_b), .busy(busy_b)
  );

  // Averaging PE model: one register stage, truncation toward zero
  function automatic logic [15:0] avg10(input logic [15:0] v [0:9]);
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) s += int'($signed(v[i]));
    return 16'(s / 10);
  endfunction

  always @(posedge clk) begin
    pe_a <= avg10(xa);
    pe_b <= avg10(xb);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the sample was taken
  task automatic send(input int d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = 16'(d);
    while (!in_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(output int data, output int ch, output int last_a,
                            output int data_b, output int ch_b, output int last_b,
                            output int lat);
    lat = 0;
    while (!res_valid_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("result_timeout", int'(res_valid_a), 1);
    data   = int'($signed(res_data_a));
    ch     = int'(res_ch_a);
    last_a = int'(res_last_a);
    data_b = int'($signed(res_data_b));
    ch_b   = int'(res_ch_b);
    last_b = int'(res_last_b);
  endtask

  typedef struct {
    logic [9:0][15:0] s;
    int               avg;
    int               ch;
  } vec_t;

  vec_t vt [5];

  initial begin
    int d, c, la, db, cb, lb, lat, stable;

    for (int i = 0; i < 10; i++) begin
      vt[0].s[i] = 16'hFFFF;
      vt[1].s[i] = 16'((i + 1) % 10);
      vt[2].s[i] = 16'(-((i + 1) % 10));
      vt[3].s[i] = 16'd32767;
      vt[4].s[i] = (i % 2 == 0) ? 16'd1000 : 16'(-1003);
    end
    vt[0].avg = -1;    vt[0].ch = 0;
    vt[1].avg = 4;     vt[1].ch = 1;
    vt[2].avg = -4;    vt[2].ch = 2;
    vt[3].avg = 32767; vt[3].ch = 3;
    vt[4].avg = -1;    vt[4].ch = 4;

    // Reset with in_valid asserted: reset must win
    in_valid = 1'b1;
    in_data  = 16'd123;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    check("rst_in_ready", int'(in_ready_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_res_valid", int'(res_valid_a), 0);
    check("rst_res_data", int'(res_data_a), 0);
    check("rst_res_ch", int'(res_ch_a), 0);
    check("rst_pe_start", int'(pe_start_a), 0);
    check("rst_x0", int'(xa[0]), 0);
    check("rst_x9", int'(xa[9]), 0);

    // 10..100 -> 55 on channel 0
    for (int i = 1; i <= 10; i++) send(i * 10);
    check("t1_pe_start", int'(pe_start_a), 1);
    check("t1_in_ready_fire", int'(in_ready_a), 0);
    get_result(d, c, la, db, cb, lb, lat);
    check("t1_data", d, 55);
    check("t1_ch", c, 0);
    check("t1_latency", lat, 6);
    check("t1_last", la, 0);
    @(negedge clk);
    check("t1_valid_pulse", int'(res_valid_a), 0);
    check("t1_in_ready_after", int'(in_ready_a), 1);

    // Table-driven windows
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) send(int'($signed(vt[k].s[i])));
      get_result(d, c, la, db, cb, lb, lat);
      check($sformatf("vec%0d_data", k), d, vt[k].avg);
      check($sformatf("vec%0d_ch", k), c, vt[k].ch);
      @(negedge clk);
    end

    // Backpressure in EMIT; an 11th sample must wait
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(3);
    get_result(d, c, la, db, cb, lb, lat);
    in_valid = 1'b1;
    in_data  = 16'd99;
    stable   = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid_a || res_data_a != 16'd3 || res_ch_a != 5'd5 || in_ready_a) stable = 0;
    end
    check("t3_emit_hold", stable, 1);
    check("t3_x0_not_overwritten", int'(xa[0]), 3);
    res_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", int'(res_valid_a), 0);
    check("t3_busy_idle", int'(busy_a), 0);
    for (int i = 0; i < 10; i++) send(99);
    get_result(d, c, la, db, cb, lb, lat);
    check("t3_next_data", d, 99);
    check("t3_next_ch", c, 6);
    @(negedge clk);

    // Reset mid-window discards the partial window
    do_reset();
    for (int i = 0; i < 6; i++) send(50);
    check("t5_busy_partial", int'(busy_a), 1);
    do_reset();
    check("t5_busy_cleared", int'(busy_a), 0);
    check("t5_x0_cleared", int'(xa[0]), 0);
    for (int i = 0; i < 10; i++) send(7);
    get_result(d, c, la, db, cb, lb, lat);
    check("t5_data", d, 7);
    check("t5_ch", c, 0);
    @(negedge clk);

    // Gapped input stream keeps slot order
    for (int i = 1; i <= 10; i++) begin
      send(i);
      @(negedge clk);
    end
    get_result(d, c, la, db, cb, lb, lat);
    check("t6_data", d, 5);
    check("t6_ch", c, 1);
    check("t6_x0", int'(xa[0]), 1);
    check("t6_x4", int'(xa[4]), 5);
    check("t6_x9", int'(xa[9]), 10);
    @(negedge clk);

    // Channel wrap on the 3-channel instance
    do_reset();
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 10; i++) send(w * 10);
      get_result(d, c, la, db, cb, lb, lat);
      check($sformatf("t4_w%0d_ch3", w), cb, w % 3);
      check($sformatf("t4_w%0d_last3", w), lb, (w == 2) ? 1 : 0);
      check($sformatf("t4_w%0d_data3", w), db, w * 10);
      check($sformatf("t4_w%0d_ch32", w), c, w);
      check($sformatf("t4_w%0d_last32", w), la, 0);
      @(negedge clk);
    end
    check("t4_last_unqualified", int'(res_last_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
